// File: rtl/sd_host_pkg.sv
// Shared definitions for the SD host datapath: transmit FSM states,
// CRC16 polynomial, line-level framing bits and the serial CRC step.
package sd_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    START,
    DATA,
    CRC,
    END
  } tx_state_t;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic        SD_START_BIT = 1'b0;
  localparam logic        SD_END_BIT   = 1'b1;

  // One bit of the CCITT CRC16 as SD sends it: MSB-first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                             input logic        bit_in);
    logic feedback;
    feedback = crc_in[15] ^ bit_in;
    return {crc_in[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 accumulator; clear wins over enable so a new frame can start
// on any cycle.
module sd_crc16
  import sd_host_pkg::*;
(
  input  logic        clk_rd,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk_rd) begin
    if (reset || clear) begin
      crc <= 16'h0000;
    end else if (enable) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_dat_tx.sv
// SD 1-bit write-block transmitter: pops words from the data FIFO and drives
// start bit, data MSB-first, CRC16 and end bit, stalling the SD clock on underrun.
module sd_dat_tx
  import sd_host_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BLOCK_WORDS = 256,
  parameter int CNT_W       = 9
) (
  input  logic                  clk_rd,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  bit_en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_request,
  output logic                  dat_out,
  output logic                  dat_oe,
  output logic                  sd_clk_stop,
  output logic                  busy,
  output logic                  done
);

  localparam int               BIT_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] WORD_LIMIT = CNT_W'(BLOCK_WORDS);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_valid;
  logic                  capture;
  logic [CNT_W-1:0]      fetched_words;
  logic [CNT_W-1:0]      sent_words;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BIT_W-1:0]      bits_left;
  logic [3:0]            crc_idx;
  logic                  end_sent;

  logic                  fetch_ok;
  logic                  at_boundary;
  logic                  words_left;
  logic                  bypass;
  logic                  word_ready;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  load_word;
  logic                  shift_bit;
  logic                  crc_clear;
  logic                  crc_en;
  logic                  crc_bit;
  logic [15:0]           crc;

  // A word arriving from the FIFO exactly at a word boundary goes straight into
  // the shifter; once stalled we wait for it to land in the holding register.
  always_comb begin
    fetch_ok    = (state != IDLE) && !empty && !hold_valid && !rd_request &&
                  !capture && (fetched_words < WORD_LIMIT);
    at_boundary = (state == DATA) && (bits_left == '0);
    words_left  = (sent_words < WORD_LIMIT);
    bypass      = capture && !sd_clk_stop;
    word_ready  = hold_valid || bypass;
    next_word   = hold_valid ? hold_reg : data_out;
    load_word   = bit_en && ((state == START) ||
                             (at_boundary && words_left && word_ready));
    shift_bit   = bit_en && (state == DATA) && (bits_left != '0);
    crc_clear   = (state == PREFETCH) && hold_valid && bit_en;
    crc_en      = load_word || shift_bit;
    crc_bit     = load_word ? next_word[DATA_WIDTH-1] : shift_reg[DATA_WIDTH-1];
  end

  sd_crc16 u_crc (
    .clk_rd (clk_rd),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  always_ff @(posedge clk_rd) begin
    if (reset) begin
      state         <= IDLE;
      dat_out       <= 1'b1;
      dat_oe        <= 1'b0;
      rd_request    <= 1'b0;
      sd_clk_stop   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hold_reg      <= '0;
      hold_valid    <= 1'b0;
      capture       <= 1'b0;
      fetched_words <= '0;
      sent_words    <= '0;
      shift_reg     <= '0;
      bits_left     <= '0;
      crc_idx       <= 4'd0;
      end_sent      <= 1'b0;
    end else begin
      done       <= 1'b0;
      rd_request <= fetch_ok;
      capture    <= rd_request;

      if (fetch_ok) begin
        fetched_words <= fetched_words + CNT_W'(1);
      end

      if (load_word) begin
        hold_valid <= 1'b0;
        shift_reg  <= {next_word[DATA_WIDTH-2:0], 1'b0};
        dat_out    <= next_word[DATA_WIDTH-1];
        bits_left  <= BIT_W'(DATA_WIDTH - 1);
        sent_words <= sent_words + CNT_W'(1);
      end

      if (capture && !(bypass && load_word)) begin
        hold_reg    <= data_out;
        hold_valid  <= 1'b1;
        sd_clk_stop <= 1'b0;
      end

      if (shift_bit) begin
        dat_out   <= shift_reg[DATA_WIDTH-1];
        shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
        bits_left <= bits_left - BIT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start && !done) begin
            state         <= PREFETCH;
            busy          <= 1'b1;
            fetched_words <= '0;
            sent_words    <= '0;
          end
        end
        PREFETCH: begin
          if (hold_valid && bit_en) begin
            dat_out <= SD_START_BIT;
            dat_oe  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_en) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_en && at_boundary) begin
            if (!words_left) begin
              dat_out <= crc[15];
              crc_idx <= 4'd14;
              state   <= CRC;
            end else if (!word_ready && !sd_clk_stop) begin
              sd_clk_stop <= 1'b1;
            end
          end
        end
        CRC: begin
          if (bit_en) begin
            dat_out <= crc[crc_idx];
            if (crc_idx == 4'd0) begin
              state <= END;
            end else begin
              crc_idx <= crc_idx - 4'd1;
            end
          end
        end
        END: begin
          if (bit_en) begin
            if (!end_sent) begin
              dat_out  <= SD_END_BIT;
              end_sent <= 1'b1;
            end else begin
              dat_oe   <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              end_sent <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_tx.sv
// Bench for sd_dat_tx: FIFO model plus a bit-level scoreboard that is loaded
// with the full expected line stream whenever a block is launched.
module tb_sd_dat_tx;

  localparam int WORDS      = 256;
  localparam int BLOCK_BITS = 1 + 16 * WORDS + 16 + 1;

  logic        clk_rd   = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic        bit_en   = 1'b0;
  logic        empty    = 1'b1;
  logic [15:0] data_out = 16'h0000;
  logic        rd_request, dat_out, dat_oe, sd_clk_stop, busy, done;

  logic [15:0] fifo_q[$];
  logic        exp_q[$];
  logic [15:0] blk[WORDS];

  int checks     = 0;
  int failures   = 0;
  int pops       = 0;
  int pops_base  = 0;
  int done_count = 0;
  int done_base  = 0;
  int block_bits = 0;
  int en_period  = 1;
  bit stop_seen  = 1'b0;

  sd_dat_tx #(.DATA_WIDTH(16), .BLOCK_WORDS(WORDS), .CNT_W(9)) dut (
    .clk_rd      (clk_rd),
    .reset       (reset),
    .start       (start),
    .bit_en      (bit_en),
    .empty       (empty),
    .data_out    (data_out),
    .rd_request  (rd_request),
    .dat_out     (dat_out),
    .dat_oe      (dat_oe),
    .sd_clk_stop (sd_clk_stop),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_rd = ~clk_rd;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Strobe generator: bit_en for the coming edge is set just after each edge.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk_rd);
      #1;
      cyc++;
      bit_en = (en_period <= 1) ? 1'b1 : ((cyc % en_period) == 0);
    end
  end

  // FIFO read port: the popped word is valid the cycle after rd_request.
  initial begin
    forever begin
      @(posedge clk_rd);
      if (rd_request && fifo_q.size() > 0) begin
        data_out <= fifo_q.pop_front();
        pops++;
      end
    end
  end

  // A bit is consumed on an edge that had bit_en with no stall before or after.
  initial begin
    bit   pend        = 1'b0;
    bit   after_reset = 1'b1;
    logic prev_out    = 1'b1;
    logic prev_oe     = 1'b0;
    logic prev_rd     = 1'b0;
    forever begin
      @(negedge clk_rd);
      empty = (fifo_q.size() == 0);
      if (reset) begin
        pend        = 1'b0;
        after_reset = 1'b1;
        block_bits  = 0;
      end else begin
        if (pend && !sd_clk_stop) begin
          if (dat_oe) begin
            checkOutput("bit_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) checkOutput("line_bit", dat_out, exp_q.pop_front());
            block_bits++;
          end
        end else if (!after_reset) begin
          checkOutput("line_hold", {dat_oe, dat_out}, {prev_oe, prev_out});
        end
        if (rd_request) checkOutput("rd_single", prev_rd, 0);
        if (sd_clk_stop) stop_seen = 1'b1;
        if (done) begin
          done_count++;
          checkOutput("bits_at_done", block_bits, BLOCK_BITS);
          block_bits = 0;
        end
        after_reset = 1'b0;
        pend = bit_en && !sd_clk_stop;
      end
      prev_out = dat_out;
      prev_oe  = dat_oe;
      prev_rd  = rd_request;
    end
  end

  function automatic logic [15:0] modelCrc();
    logic [15:0] c = 16'h0000;
    logic        fb;
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 15; b >= 0; b--) begin
        fb = blk[w][b] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic loadExpected(input logic [15:0] crc_exp);
    exp_q.push_back(1'b0);
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 15; b >= 0; b--) exp_q.push_back(blk[w][b]);
    end
    for (int b = 15; b >= 0; b--) exp_q.push_back(crc_exp[b]);
    exp_q.push_back(1'b1);
  endtask

  task automatic fillFifo(input int first, input int last);
    for (int i = first; i < last; i++) fifo_q.push_back(blk[i]);
  endtask

  task automatic applyStimulus();
    @(posedge clk_rd);
    #1 start = 1'b1;
    @(posedge clk_rd);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    while (done_count == done_base && k < budget) begin
      @(posedge clk_rd);
      k++;
    end
    checkOutput("done_seen", done_count - done_base, 1);
  endtask

  task automatic waitBits(input int n, input int budget);
    int k = 0;
    while (block_bits < n && k < budget) begin
      @(posedge clk_rd);
      k++;
    end
    checkOutput("bits_reached", 32'(block_bits >= n), 1);
  endtask

  task automatic launchBlock();
    pops_base = pops;
    done_base = done_count;
    stop_seen = 1'b0;
    applyStimulus();
    @(negedge clk_rd);
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic finishBlock(input string tag);
    @(negedge clk_rd);
    checkOutput({tag, "_pops"}, pops - pops_base, WORDS);
    checkOutput({tag, "_scoreboard_left"}, exp_q.size(), 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_oe"}, dat_oe, 0);
    checkOutput({tag, "_out"}, dat_out, 1);
  endtask

  initial begin
    int k;
    $display("[TB] sd_dat_tx bench starting");

    repeat (3) @(posedge clk_rd);
    #1 reset = 1'b0;
    @(negedge clk_rd);
    checkOutput("rst_dat_out", dat_out, 1);
    checkOutput("rst_dat_oe", dat_oe, 0);
    checkOutput("rst_rd_request", rd_request, 0);
    checkOutput("rst_clk_stop", sd_clk_stop, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);

    $display("[TB] all-ones block, FIFO pre-filled");
    en_period = 1;
    for (int i = 0; i < WORDS; i++) blk[i] = 16'hFFFF;
    fillFifo(0, WORDS);
    loadExpected(16'h7FA1);
    launchBlock();
    waitDone(6000);
    finishBlock("ones");

    $display("[TB] all-zero block");
    for (int i = 0; i < WORDS; i++) blk[i] = 16'h0000;
    fillFifo(0, WORDS);
    loadExpected(16'h0000);
    launchBlock();
    waitDone(6000);
    finishBlock("zeros");

    $display("[TB] incrementing block with FIFO underrun after word 10");
    for (int i = 0; i < WORDS; i++) blk[i] = 16'(i + 1);
    fillFifo(0, 10);
    loadExpected(modelCrc());
    launchBlock();
    k = 0;
    while ((pops - pops_base) < 10 && k < 1000) begin
      @(posedge clk_rd);
      k++;
    end
    checkOutput("gap_pops_10", pops - pops_base, 10);
    repeat (50) @(posedge clk_rd);
    checkOutput("gap_clk_stop", sd_clk_stop, 1);
    #1 fillFifo(10, WORDS);
    waitDone(6000);
    checkOutput("gap_stop_seen", stop_seen, 1);
    finishBlock("gap");

    $display("[TB] sparse strobes, overfull FIFO, stray starts");
    en_period = 4;
    for (int i = 0; i < WORDS; i++) blk[i] = 16'($urandom);
    fillFifo(0, WORDS);
    for (int i = 0; i < 20; i++) fifo_q.push_back(16'($urandom));
    loadExpected(modelCrc());
    launchBlock();
    repeat (100) @(posedge clk_rd);
    applyStimulus();
    @(negedge clk_rd);
    checkOutput("busy_after_stray_start", busy, 1);
    waitBits(BLOCK_BITS, 20000);
    k = 0;
    while (k < 16) begin
      #2;
      if (bit_en) break;
      @(posedge clk_rd);
      k++;
    end
    @(posedge clk_rd);
    #1 start = 1'b1;
    @(negedge clk_rd);
    checkOutput("done_coincident", done, 1);
    @(posedge clk_rd);
    #1 start = 1'b0;
    repeat (20) @(posedge clk_rd);
    @(negedge clk_rd);
    checkOutput("done_once", done_count - done_base, 1);
    checkOutput("sparse_busy", busy, 0);
    checkOutput("sparse_pops", pops - pops_base, WORDS);
    checkOutput("sparse_fifo_left", fifo_q.size(), 20);
    checkOutput("sparse_scoreboard_left", exp_q.size(), 0);
    fifo_q.delete();

    $display("[TB] reset in the middle of word 100");
    en_period = 1;
    for (int i = 0; i < WORDS; i++) blk[i] = 16'($urandom);
    fillFifo(0, WORDS);
    loadExpected(modelCrc());
    launchBlock();
    waitBits(1 + 16 * 100 + 5, 6000);
    @(posedge clk_rd);
    #1 reset = 1'b1;
    exp_q.delete();
    fifo_q.delete();
    @(posedge clk_rd);
    #1 reset = 1'b0;
    @(negedge clk_rd);
    checkOutput("midrst_dat_oe", dat_oe, 0);
    checkOutput("midrst_dat_out", dat_out, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rd_request", rd_request, 0);
    checkOutput("midrst_clk_stop", sd_clk_stop, 0);

    $display("[TB] fresh block after reset");
    for (int i = 0; i < WORDS; i++) blk[i] = 16'(16'hA5C3 ^ (i * 16'h0101));
    fillFifo(0, WORDS);
    loadExpected(modelCrc());
    launchBlock();
    waitDone(6000);
    finishBlock("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_dat_tx.md
Name: sd_dat_tx

Overview:
- Read-side consumer of the dual-clock data FIFO.
- Pulls 16-bit words from the FIFO and serialises them as one SD single-line (1-bit mode) write data block: start bit, data MSB-first, CRC16, end bit.
- Lives in the clk_rd domain, between the FIFO and the SD pad/clock generator.
- Stalls the SD clock instead of corrupting the block when the FIFO runs dry.

Parameters:
- DATA_WIDTH, 16, FIFO word width in bits.
- BLOCK_WORDS, 256, words per block (256 x 16 bits = 512 bytes).
- CNT_W, 9, width of the word counter; must satisfy 2^CNT_W > BLOCK_WORDS.

Ports:
- clk_rd  in  1  block clock, same as the FIFO read clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a block; ignored while busy=1.
- bit_en  in  1  SD bit strobe; the line advances only on cycles where bit_en=1.
- empty  in  1  FIFO empty flag.
- data_out  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted rd_request.
- rd_request  out  1  one-cycle FIFO pop request.
- dat_out  out  1  SD DAT0 value.
- dat_oe  out  1  DAT0 output enable.
- sd_clk_stop  out  1  tells the clock generator to gate the SD clock (underrun stall).
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the end bit.

Behaviour:
- Reset values: dat_out=1, dat_oe=0, rd_request=0, sd_clk_stop=0, busy=0, done=0, state=IDLE. Counters, CRC and holding register are cleared.
- Reset mid-block: return to IDLE next edge and discard any prefetched word. The FIFO is not rewound; upper layer flushes it.
- FIFO handshake:
  - rd_request is asserted for one cycle only when: empty=0, hold_valid=0, no request is already in flight, and fetched_words < BLOCK_WORDS.
  - The word is captured into the holding register from data_out on the next cycle; hold_valid is set.
  - At most one request is outstanding.
- States and transitions:
  - IDLE: start -> PREFETCH; busy=1.
  - PREFETCH: line idle (dat_oe=0). When hold_valid=1 and bit_en=1 -> START: dat_out=0, dat_oe=1, CRC cleared.
  - START: on bit_en, load shift register from holding (hold_valid=0), dat_out=bit15 -> DATA.
  - DATA: each bit_en shifts out the next bit and feeds the CRC.
    - After bit0 of a word, if sent_words < BLOCK_WORDS: load the next word from holding.
    - If hold_valid=0 at that boundary: enter stall. Hold dat_out at its current value, assert sd_clk_stop, ignore bit_en. Resume on the first bit_en after hold_valid=1, and drop sd_clk_stop the cycle hold_valid rises.
    - After the last bit of word BLOCK_WORDS -> CRC state.
  - CRC: 16 bit_en cycles output CRC MSB-first -> END.
  - END: on bit_en, dat_out=1 (end bit).
  - Next bit_en: dat_oe=0, done=1 for one cycle, busy=0 -> IDLE.
- Total driven bits per block: 1 + 16*BLOCK_WORDS + 16 + 1 = 4114 at default.
- CRC16: CCITT polynomial x^16+x^12+x^5+1 (0x1021), init 0x0000, computed over data bits only.
- Simultaneous events: a start pulse in the same cycle as done is ignored. bit_en is ignored in IDLE.
- Prefetch never pops more than BLOCK_WORDS words per block.

Decomposition:
- Shared package sd_host_pkg holds:
  - the state enum (IDLE, PREFETCH, START, DATA, CRC, END);
  - CRC16_POLY = 16'h1021;
  - SD_START_BIT = 0 and SD_END_BIT = 1.
- Sub-module sd_crc16: serial CRC with ports clk_rd, reset, clear, enable, bit_in, crc[15:0]. It is reused by the command and receive paths.

Test Plan:
- BLOCK_WORDS=256 of 16'hFFFF, FIFO pre-filled, bit_en always 1 -> 0, 4096 ones, CRC 16'h7FA1, 1; done 4114 bit_en cycles after START; exactly 256 pops.
- All-zero block, BLOCK_WORDS=4 -> start 0, 64 zeros, CRC 16'h0000, end 1; dat_oe low before start and after end.
- Incrementing words 1..256 with FIFO emptied after word 10 for 50 cycles -> sd_clk_stop high for the gap; dat_out frozen; bit stream identical to the no-gap run (compare against the model's CRC).
- bit_en pulsed once every 4 cycles -> line changes only on strobes; rd_request never more than one ahead; no pop beyond BLOCK_WORDS even with a full FIFO.
- reset asserted mid-DATA (word 100) -> next edge dat_oe=0, dat_out=1, busy=0, rd_request=0; a fresh start after reset produces a correct block.
- start pulsed during busy and coincident with done -> ignored; exactly one done per accepted start.
